// File: rtl/way_data_mux.sv
// way_data_mux: selects the data word of the hitting way from a set-associative
// lookup and presents it through a 2-entry skid buffer, with hit/miss statistics.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   lookup result presented          in_ready   input accepted (registered)
//   way_data   WAYS concatenated data words     hit_vec    per-way tag-match flags
//   out_valid  result presented                 out_ready  consumer accepts result
//   out_data   selected way word                out_way    index of selected way
//   out_hit    at least one way hit             out_multi  more than one way hit
//   clr_cnt    synchronous clear of counters
//   hit_cnt    saturating accepted-hit count    miss_cnt   saturating accepted-miss count
module way_data_mux #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned WAYS   = 4,
  localparam int unsigned SEL_W  = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WAYS*DATA_W-1:0] way_data,
  input  logic [WAYS-1:0]        hit_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_way,
  output logic                   out_hit,
  output logic                   out_multi,
  input  logic                   clr_cnt,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  way;
    logic              hit;
    logic              multi;
  } result_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t      state_q;
  result_t     main_q;
  result_t     skid_q;
  result_t     new_res;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] hit_cnt_d;
  logic [15:0] miss_cnt_q;
  logic [15:0] miss_cnt_d;
  logic        in_xfer;
  logic        out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // Lowest-index hit wins; a second hit anywhere flags multi without
  // changing the selection. With no hit the result stays all zero.
  always_comb begin
    new_res = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (hit_vec[i]) begin
        if (new_res.hit) begin
          new_res.multi = 1'b1;
        end else begin
          new_res.hit  = 1'b1;
          new_res.way  = SEL_W'(i);
          new_res.data = way_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Skid buffer control. in_ready is a flop that tracks "next state is not
  // TWO", so it never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q <= 1'b1;
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            main_q      <= new_res;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_q     <= new_res;
            state_q    <= S_TWO;
            in_ready_q <= 1'b0;
          end else if (out_xfer && !in_xfer) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            main_q <= new_res;
          end
        end
        S_TWO: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state_q <= S_ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (clr_cnt) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (in_xfer) begin
      if (|hit_vec) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q.data;
  assign out_way   = main_q.way;
  assign out_hit   = main_q.hit;
  assign out_multi = main_q.multi;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_way_data_mux.sv
module tb_way_data_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] way_data = '0;
  logic [3:0]  hit_vec = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_way;
  logic        out_hit;
  logic        out_multi;
  logic        clr_cnt = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int nvec = 0;
  int nerr = 0;

  way_data_mux #(.DATA_W(16), .WAYS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .way_data(way_data), .hit_vec(hit_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_way(out_way),
    .out_hit(out_hit), .out_multi(out_multi), .clr_cnt(clr_cnt),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    nvec++;
    if ({in_ready, out_valid, out_data, out_way, out_hit, out_multi, hit_cnt, miss_cnt} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h way=%0d hit=%b multi=%b hc=%h mc=%h, want all 0",
               in_ready, out_valid, out_data, out_way, out_hit, out_multi, hit_cnt, miss_cnt);
    end
    tick();
    rst = 1'b1;
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL reset_release_ready: got %b want 0", in_ready);
    end
    tick();
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL ready_after_reset: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_hit();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    hit_vec   = 4'b0100;
    way_data  = {16'h3333, 16'hBEEF, 16'h1111, 16'h0AAA};
    tick();
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_way !== 2'd2 || out_hit !== 1'b1 ||
        out_multi !== 1'b0 || hit_cnt !== 16'd1) begin
      nerr++;
      $display("FAIL single_hit: got vld=%b data=%h way=%0d hit=%b multi=%b hc=%0d want 1 beef 2 1 0 1",
               out_valid, out_data, out_way, out_hit, out_multi, hit_cnt);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL single_hit_drain: got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_miss_multi();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    hit_vec   = 4'b0000;
    way_data  = {16'h4444, 16'h5555, 16'h6666, 16'h7777};
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_hit !== 1'b0 || out_way !== 2'd0 ||
        out_multi !== 1'b0 || miss_cnt !== 16'd1 || hit_cnt !== 16'd1) begin
      nerr++;
      $display("FAIL miss: got vld=%b data=%h hit=%b way=%0d multi=%b mc=%0d hc=%0d want 1 0000 0 0 0 1 1",
               out_valid, out_data, out_hit, out_way, out_multi, miss_cnt, hit_cnt);
    end
    hit_vec = 4'b1010;
    tick();
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || out_way !== 2'd1 || out_multi !== 1'b1 || out_hit !== 1'b1 ||
        out_data !== 16'h6666 || hit_cnt !== 16'd2) begin
      nerr++;
      $display("FAIL multi_hit: got vld=%b way=%0d multi=%b hit=%b data=%h hc=%0d want 1 1 1 1 6666 2",
               out_valid, out_way, out_multi, out_hit, out_data, hit_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    hit_vec   = 4'b0001;
    way_data  = {48'h0, 16'hA0A0};
    tick();
    way_data  = {48'h0, 16'hB0B0};
    nvec++;
    if (in_ready !== 1'b1 || out_data !== 16'hA0A0) begin
      nerr++; $display("FAIL bp_after_A: got rdy=%b data=%h want 1 a0a0", in_ready, out_data);
    end
    tick();
    way_data = {48'h0, 16'hC0C0};
    nvec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'hA0A0) begin
      nerr++; $display("FAIL bp_full: got rdy=%b vld=%b data=%h want 0 1 a0a0", in_ready, out_valid, out_data);
    end
    tick();
    tick();
    nvec++;
    if (in_ready !== 1'b0 || out_data !== 16'hA0A0 || out_way !== 2'd0 || out_hit !== 1'b1) begin
      nerr++; $display("FAIL bp_hold: got rdy=%b data=%h way=%0d hit=%b want 0 a0a0 0 1",
                       in_ready, out_data, out_way, out_hit);
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 16'hB0B0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_second: got vld=%b data=%h rdy=%b want 1 b0b0 1", out_valid, out_data, in_ready);
    end
    tick();
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 16'hC0C0) begin
      nerr++; $display("FAIL bp_third: got vld=%b data=%h want 1 c0c0", out_valid, out_data);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || hit_cnt !== 16'd5) begin
      nerr++; $display("FAIL bp_drain: got vld=%b hc=%0d want 0 5", out_valid, hit_cnt);
    end
  endtask

  task automatic test_stream();
    logic [15:0] ed;
    logic [1:0]  ew;
    logic        eh;
    logic        em;
    logic [3:0]  hv;
    logic [63:0] wd;
    int          base;
    int          bad;
    base = int'(hit_cnt) + int'(miss_cnt);
    bad  = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      hv = 4'($urandom);
      wd = {$urandom, $urandom};
      in_valid = 1'b1;
      hit_vec  = hv;
      way_data = wd;
      ed = '0; ew = '0; eh = 1'b0;
      for (int i = 3; i >= 0; i--) begin
        if (hv[i]) begin
          ed = wd[i*16 +: 16];
          ew = 2'(i);
          eh = 1'b1;
        end
      end
      em = ($countones(hv) > 1);
      tick();
      nvec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== ed || out_way !== ew ||
          out_hit !== eh || out_multi !== em) begin
        nerr++;
        $display("FAIL stream[%0d]: got vld=%b rdy=%b data=%h way=%0d hit=%b multi=%b want 1 1 %h %0d %b %b",
                 k, out_valid, in_ready, out_data, out_way, out_hit, out_multi, ed, ew, eh, em);
      end
    end
    in_valid = 1'b0;
    tick();
    nvec++;
    if (out_valid !== 1'b0 || (int'(hit_cnt) + int'(miss_cnt) - base) != 100) begin
      nerr++;
      $display("FAIL stream_count: got vld=%b delta=%0d want 0 100", out_valid,
               int'(hit_cnt) + int'(miss_cnt) - base);
    end
    if (bad != 0) nerr++;
  endtask

  task automatic test_sat_clear();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    nvec++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      nerr++; $display("FAIL clear_idle: got hc=%h mc=%h want 0 0", hit_cnt, miss_cnt);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    hit_vec   = 4'b0001;
    way_data  = 64'h1;
    repeat (65535) tick();
    nvec++;
    if (hit_cnt !== 16'hFFFF) begin
      nerr++; $display("FAIL reach_max: got hc=%h want ffff", hit_cnt);
    end
    tick();
    nvec++;
    if (hit_cnt !== 16'hFFFF || miss_cnt !== 16'd0) begin
      nerr++; $display("FAIL saturate: got hc=%h mc=%h want ffff 0", hit_cnt, miss_cnt);
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    nvec++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      nerr++; $display("FAIL clear_priority: got hc=%h mc=%h want 0 0", hit_cnt, miss_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    hit_vec   = 4'b1000;
    way_data  = {16'hAAAA, 48'h0};
    tick();
    way_data  = {16'hBBBB, 48'h0};
    tick();
    in_valid = 1'b0;
    nvec++;
    if (in_ready !== 1'b0 || hit_cnt !== 16'd2) begin
      nerr++; $display("FAIL mid_full: got rdy=%b hc=%0d want 0 2", in_ready, hit_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || in_ready !== 1'b0 ||
        out_data !== 16'd0) begin
      nerr++;
      $display("FAIL async_reset: got vld=%b hc=%h mc=%h rdy=%b data=%h want 0 0 0 0 0",
               out_valid, hit_cnt, miss_cnt, in_ready, out_data);
    end
    #1;
    rst = 1'b1;
    tick();
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL mid_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    in_valid = 1'b1;
    hit_vec  = 4'b0010;
    way_data = {32'h0, 16'hD00D, 16'h0};
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 16'hD00D || out_way !== 2'd1) begin
      nerr++; $display("FAIL mid_new: got vld=%b data=%h way=%0d want 1 d00d 1", out_valid, out_data, out_way);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL mid_no_stale: got vld=%b data=%h want vld 0", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss_multi();
    test_backpressure();
    test_stream();
    test_sat_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
